// File: rtl/key_command_scheduler.sv
// key_command_scheduler: turns keyboard make/break strobes into movement, fire and pause commands.
// Define AUTOFIRE_EN to add a REPEAT state that re-fires while the fire key stays held.
module key_command_scheduler #(
    parameter logic [8:0] KEY_LEFT        = 9'h06B,
    parameter logic [8:0] KEY_RIGHT       = 9'h074,
    parameter logic [8:0] KEY_FIRE        = 9'h029,
    parameter logic [8:0] KEY_PAUSE       = 9'h076,
    parameter int         FIRE_COOLDOWN   = 12_500_000,
    parameter int         AUTOFIRE_PERIOD = 25_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    input  logic       clear,
    output logic       moveLeft,
    output logic       moveRight,
    output logic       firePulse,
    output logic       paused
);
`ifdef AUTOFIRE_EN
    typedef enum logic [1:0] {IDLE, COOLDOWN, REPEAT} state_t;
    localparam logic [25:0] AF_LOAD = 26'(AUTOFIRE_PERIOD - 1);
`else
    typedef enum logic {IDLE, COOLDOWN} state_t;
`endif
    localparam logic [25:0] CD_LOAD = 26'(FIRE_COOLDOWN - 1);
    localparam logic LEFT = 1'b0;
    localparam logic RIGHT = 1'b1;

    state_t      state, state_nxt;
    logic [25:0] cnt, cnt_nxt;
    logic        left_q, right_q, fire_q, pause_q;
    logic        fire_prev, pause_prev, last_dir;
    logic        pulse_nxt, paused_nxt, fire_edge, pause_edge;

    // brakee wins over make when both strobe the same code
    function automatic logic upd(input logic flag, input logic hit);
        return hit ? (brakee ? 1'b0 : (make ? 1'b1 : flag)) : flag;
    endfunction

    assign fire_edge  = fire_q & ~fire_prev;
    assign pause_edge = pause_q & ~pause_prev;
    assign paused_nxt = clear ? 1'b0 : paused ^ pause_edge;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            fire_q     <= 1'b0;
            pause_q    <= 1'b0;
            fire_prev  <= 1'b0;
            pause_prev <= 1'b0;
            last_dir   <= LEFT;
            state      <= IDLE;
            cnt        <= '0;
            moveLeft   <= 1'b0;
            moveRight  <= 1'b0;
            firePulse  <= 1'b0;
            paused     <= 1'b0;
        end else begin
            left_q     <= upd(left_q, keyCode == KEY_LEFT);
            right_q    <= upd(right_q, keyCode == KEY_RIGHT);
            fire_q     <= upd(fire_q, keyCode == KEY_FIRE);
            pause_q    <= upd(pause_q, keyCode == KEY_PAUSE);
            fire_prev  <= fire_q;
            pause_prev <= pause_q;
            if (make && !brakee && keyCode == KEY_LEFT) last_dir <= LEFT;
            else if (make && !brakee && keyCode == KEY_RIGHT) last_dir <= RIGHT;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            moveLeft   <= ~paused_nxt & left_q & (~right_q | last_dir == LEFT);
            moveRight  <= ~paused_nxt & right_q & (~left_q | last_dir == RIGHT);
            firePulse  <= pulse_nxt;
            paused     <= paused_nxt;
        end
    end

    // the whole fire FSM freezes while paused, so edges are dropped and the count holds
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (!paused_nxt) begin
            case (state)
                IDLE: if (fire_edge) begin
                    pulse_nxt = 1'b1;
                    cnt_nxt   = CD_LOAD;
                    state_nxt = COOLDOWN;
                end
                COOLDOWN: if (cnt == '0) begin
`ifdef AUTOFIRE_EN
                    state_nxt = fire_q ? REPEAT : IDLE;
                    cnt_nxt   = fire_q ? AF_LOAD : '0;
`else
                    state_nxt = IDLE;
`endif
                end else cnt_nxt = cnt - 26'd1;
`ifdef AUTOFIRE_EN
                REPEAT: if (!fire_q) begin
                    state_nxt = COOLDOWN;
                    cnt_nxt   = CD_LOAD;
                end else if (cnt == '0) begin
                    pulse_nxt = 1'b1;
                    cnt_nxt   = AF_LOAD;
                end else cnt_nxt = cnt - 26'd1;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_command_scheduler.sv
// tb_key_command_scheduler: directed checks of direction, fire cooldown, pause, clear and reset.
// Strobes are driven for one cycle; outputs are sampled 1 time unit after each rising edge.
module tb_key_command_scheduler;
    localparam logic [8:0] KL = 9'h06B, KR = 9'h074, KF = 9'h029, KP = 9'h076;
`ifdef AUTOFIRE_EN
    localparam bit AF = 1'b1;
`else
    localparam bit AF = 1'b0;
`endif

    logic clk = 1'b0, resetN = 1'b1, make = 1'b0, brakee = 1'b0, clear = 1'b0;
    logic [8:0] keyCode = '0;
    logic moveLeft, moveRight, firePulse, paused;
    int errors = 0, checks = 0;

    key_command_scheduler #(.FIRE_COOLDOWN(4), .AUTOFIRE_PERIOD(6)) dut (
        .clk(clk), .resetN(resetN), .keyCode(keyCode), .make(make), .brakee(brakee),
        .clear(clear), .moveLeft(moveLeft), .moveRight(moveRight),
        .firePulse(firePulse), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [8:0] c, input logic m, input logic b);
        keyCode = c;
        make    = m;
        brakee  = b;
        tick();
        make    = 1'b0;
        brakee  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic r, input logic f, input logic p);
        chk({tag, "_left"}, moveLeft, l);
        chk({tag, "_right"}, moveRight, r);
        chk({tag, "_fire"}, firePulse, f);
        chk({tag, "_paused"}, paused, p);
    endtask

    initial begin
        #2 resetN = 1'b0;
        #1 chk_all("reset", 0, 0, 0, 0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        tick();
        // last-pressed direction wins
        step(KL, 1, 0);
        chk("left_n1", moveLeft, 1'b0);
        tick();
        chk_all("left_n2", 1, 0, 0, 0);
        step(KR, 1, 0);
        chk("right_n1_left", moveLeft, 1'b1);
        tick();
        chk_all("right_wins", 0, 1, 0, 0);
        step(KR, 0, 1);
        tick();
        chk_all("right_released", 1, 0, 0, 0);
        step(9'h1AA, 1, 0);
        tick();
        chk_all("nonmatching", 1, 0, 0, 0);
        step(KL, 0, 1);
        tick();
        chk_all("left_released", 0, 0, 0, 0);
        // single pulse per press; press during cooldown dropped
        step(KF, 1, 0);
        chk("fire_n1", firePulse, 1'b0);
        step(KF, 0, 1);
        chk("fire_n2", firePulse, 1'b1);
        tick();
        chk("fire_one_cycle", firePulse, 1'b0);
        step(KF, 1, 0);
        chk("cooldown_press_a", firePulse, 1'b0);
        step(KF, 0, 1);
        chk("cooldown_press_b", firePulse, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cooldown_quiet", firePulse, 1'b0);
        end
        // held fire: one pulse, or periodic repeats with autofire
        step(KF, 1, 0);
        for (int k = 1; k <= 40; k++) begin
            chk($sformatf("hold_fire_k%0d", k), firePulse,
                k == 2 || (AF && k >= 12 && k <= 30 && (k - 12) % 6 == 0));
            if (k == 30) step(KF, 0, 1);
            else tick();
        end
        // simultaneous make and brakee leaves the flag clear
        step(KF, 1, 1);
        tick();
        chk("both_strobes", firePulse, 1'b0);
        step(KF, 1, 0);
        tick();
        chk("after_both_strobes", firePulse, 1'b1);
        step(KF, 0, 1);
        for (int i = 0; i < 8; i++) tick();
        // async reset mid-cooldown
        step(KL, 1, 0);
        tick();
        chk("pre_reset_left", moveLeft, 1'b1);
        step(KF, 1, 0);
        step(KF, 0, 1);
        chk("pre_reset_fire", firePulse, 1'b1);
        tick();
        resetN = 1'b0;
        #1 chk_all("async_reset", 0, 0, 0, 0);
        #1 resetN = 1'b1;
        tick();
        step(KF, 1, 0);
        chk("post_reset_n1", firePulse, 1'b0);
        tick();
        chk("post_reset_n2", firePulse, 1'b1);
        step(KF, 0, 1);
        for (int i = 0; i < 6; i++) tick();
        // pause blocks movement and fire
        step(KP, 1, 0);
        chk("pause_n1", paused, 1'b0);
        step(KP, 0, 1);
        chk("pause_n2", paused, 1'b1);
        step(KL, 1, 0);
        tick();
        chk_all("paused_left", 0, 0, 0, 1);
        step(KF, 1, 0);
        tick();
        chk("paused_fire", firePulse, 1'b0);
        step(KF, 0, 1);
        tick();
        chk("paused_fire_b", firePulse, 1'b0);
        step(KP, 1, 0);
        chk("unpause_n1", paused, 1'b1);
        tick();
        chk_all("unpaused", 1, 0, 0, 0);
        step(KP, 0, 1);
        // clear beats a coinciding pause edge
        step(KP, 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all("clear_vs_pause", 1, 0, 0, 0);
        step(KP, 0, 1);
        step(KP, 1, 0);
        tick();
        chk("pause_again", paused, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all("clear_unpauses", 1, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_command_scheduler.md
KEY_COMMAND_SCHEDULER -- requirements
Module: key_command_scheduler

Interface
REQ-001 Parameter KEY_LEFT, default 9'h06B, scan code of the move-left key.
REQ-002 Parameter KEY_RIGHT, default 9'h074, scan code of the move-right key.
REQ-003 Parameter KEY_FIRE, default 9'h029, scan code of the fire key.
REQ-004 Parameter KEY_PAUSE, default 9'h076, scan code of the pause key.
REQ-005 Parameter FIRE_COOLDOWN, default 12_500_000, minimum clocks between fire pulses (valid range 2..2^26-1).
REQ-006 Parameter AUTOFIRE_PERIOD, default 25_000_000, clocks between repeat shots while fire is held (used only when AUTOFIRE_EN is defined).
REQ-007 clk  input  1  system clock.
REQ-008 resetN  input  1  asynchronous, active-low reset.
REQ-009 keyCode  input  9  scan code from the keyboard front end.
REQ-010 make  input  1  single-cycle strobe: keyCode pressed.
REQ-011 brakee  input  1  single-cycle strobe: keyCode released.
REQ-012 clear  input  1  synchronous game-restart request.
REQ-013 moveLeft  output  1  player moves left.
REQ-014 moveRight  output  1  player moves right.
REQ-015 firePulse  output  1  one-clock shot request.
REQ-016 paused  output  1  game paused.

Function
REQ-017 Per key, a pressed flag SHALL be set on make and cleared on brakee when keyCode matches; if both strobes are asserted in one cycle, brakee SHALL win. Non-matching codes SHALL be ignored.
REQ-018 Pressed flags SHALL update at the edge ending the strobe cycle N; all four outputs SHALL be registers derived from the flags, visible in cycle N+2.
REQ-019 Direction SHALL be last-pressed-wins: a lastDir register records the most recent left/right make. moveLeft = leftPressed & (~rightPressed | lastDir==LEFT); moveRight symmetric. moveLeft and moveRight SHALL never be high together.
REQ-020 If the active direction key is released while the other key is still held, the other direction SHALL assert in the same cycle the active one deasserts.
REQ-021 Fire FSM states: IDLE, COOLDOWN.
REQ-022 In IDLE, a rising edge of the fire flag SHALL assert firePulse for exactly one cycle, load the 26-bit counter with FIRE_COOLDOWN-1, and enter COOLDOWN.
REQ-023 In COOLDOWN, the counter SHALL decrement each cycle and the FSM SHALL return to IDLE on the cycle after the counter reaches 0. Fire edges in COOLDOWN SHALL be discarded, not queued.
REQ-024 A rising edge of the pause flag SHALL toggle paused.
REQ-025 While paused=1: moveLeft, moveRight and firePulse SHALL be 0, the cooldown counter SHALL hold its value, and flag tracking SHALL continue.
REQ-026 A fire edge occurring while paused SHALL be discarded.
REQ-027 clear=1 SHALL, at the next edge, set paused=0, set the FSM to IDLE, set the counter to 0 and drive firePulse=0. Pressed flags and lastDir SHALL be unaffected.
REQ-028 If clear and a pause edge coincide, clear SHALL win.

Reset
REQ-029 On resetN=0, all pressed flags, lastDir (LEFT), the counter, moveLeft, moveRight, firePulse and paused SHALL be 0, and the FSM SHALL be IDLE, immediately and asynchronously.
REQ-030 Reset asserted mid-cooldown SHALL abort the cooldown; after reset release, the first fire edge SHALL fire without waiting.

Configuration
REQ-031 Macro AUTOFIRE_EN: when defined, the FSM SHALL add state REPEAT.
REQ-032 With AUTOFIRE_EN defined, when COOLDOWN expires while fire is held, the FSM SHALL enter REPEAT and issue firePulse every AUTOFIRE_PERIOD clocks until fire is released, then enter COOLDOWN.
REQ-033 Without AUTOFIRE_EN, holding fire SHALL produce exactly one pulse per press, and no REPEAT logic SHALL be synthesized.

Verification (bench overrides FIRE_COOLDOWN=4, AUTOFIRE_PERIOD=6)
REQ-034 make with 9'h06B at cycle 10 -> moveLeft=1 from cycle 12; then make with 9'h074 at cycle 20 -> moveRight=1 and moveLeft=0 from cycle 22; then brakee with 9'h074 at cycle 30 -> moveLeft=1 from cycle 32.
REQ-035 fire make at cycle 10, fire brakee at cycle 11, fire make at cycle 13 -> single firePulse at cycle 12 and none for the cycle-13 press; a make at cycle 20 -> firePulse at cycle 22.
REQ-036 pause make, then left make -> paused=1, moveLeft stays 0; second pause press -> paused=0 and moveLeft=1 two cycles after the edge.
REQ-037 make and brakee both asserted with 9'h029 in one cycle -> no firePulse and fire flag stays 0.
REQ-038 resetN pulsed low during COOLDOWN (counter=2) -> all outputs 0 at once; a fire press after release -> pulse at N+2.
REQ-039 AUTOFIRE_EN defined, fire held 30 cycles -> first pulse at N+2, then pulses every 6 cycles after REPEAT entry; none after release.
